// File: rtl/axo32_decoder.sv
// axo32_decoder: registered RV32I instruction decoder (flags, register fields, immediate, validity)
module axo32_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic        op_valid,
    output logic        op_will_read,
    output logic        op_will_write,
    output logic        op_uses_alu,
    output logic        op_does_flowctl,
    output logic        op_is_ecall,
    output logic        op_is_ebreak,
    output logic        op_32bit,
    output logic        op_is_imm,
    output logic [31:0] imm,
    output logic        rd_we,
    output logic        rs1_re,
    output logic        rs2_re,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        valid, rd_m, wr_m, alu, flow, ecall, ebreak, is_imm, we, r1, r2;
    logic [31:0] imm_d;
    logic [58:0] dec_d, dec_q;
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // opcode/funct decode; anything illegal collapses to all-zero flags and immediate
    always_comb begin
        valid = 1'b0;
        {rd_m, wr_m, alu, flow, ecall, ebreak, is_imm, we, r1, r2} = '0;
        imm_d = '0;
        case (inst[6:0])
            7'b0110111: begin valid = 1'b1; imm_d = imm_u; we = 1'b1; is_imm = 1'b1; end
            7'b0010111: begin valid = 1'b1; imm_d = imm_u; we = 1'b1; is_imm = 1'b1; alu = 1'b1; end
            7'b1101111: begin valid = 1'b1; imm_d = imm_j; we = 1'b1; is_imm = 1'b1; flow = 1'b1; end
            7'b1100111: begin
                valid = f3 == 3'b000;
                imm_d = imm_i; we = 1'b1; r1 = 1'b1; is_imm = 1'b1; flow = 1'b1;
            end
            7'b1100011: begin
                valid = f3[2:1] != 2'b01;
                imm_d = imm_b; r1 = 1'b1; r2 = 1'b1; flow = 1'b1;
            end
            7'b0000011: begin
                valid = !(f3 == 3'b011 || f3[2:1] == 2'b11);
                imm_d = imm_i; we = 1'b1; r1 = 1'b1; is_imm = 1'b1; rd_m = 1'b1;
            end
            7'b0100011: begin
                valid = f3 < 3'd3;
                imm_d = imm_s; r1 = 1'b1; r2 = 1'b1; wr_m = 1'b1;
            end
            7'b0010011: begin
                valid = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
                imm_d = imm_i; we = 1'b1; r1 = 1'b1; is_imm = 1'b1; alu = 1'b1;
            end
            7'b0110011: begin
                valid = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                we = 1'b1; r1 = 1'b1; r2 = 1'b1; alu = 1'b1;
            end
            7'b0001111: valid = 1'b1;
            7'b1110011: begin
                ecall  = inst == 32'h0000_0073;
                ebreak = inst == 32'h0010_0073;
                valid  = ecall | ebreak;
            end
            default: valid = 1'b0;
        endcase
        if (inst[1:0] != 2'b11 || !valid) begin
            valid = 1'b0;
            {rd_m, wr_m, alu, flow, ecall, ebreak, is_imm, we, r1, r2} = '0;
            imm_d = '0;
        end
        we = we && inst[11:7] != 5'd0;
        dec_d = {valid, inst[1:0] == 2'b11, rd_m, wr_m, alu, flow, ecall, ebreak, is_imm, we, r1, r2,
                 imm_d, inst[11:7], inst[19:15], inst[24:20]};
    end
    // one-cycle decode register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_q <= '0;
        else        dec_q <= dec_d;
    end
    assign {op_valid, op_32bit, op_will_read, op_will_write, op_uses_alu, op_does_flowctl,
            op_is_ecall, op_is_ebreak, op_is_imm, rd_we, rs1_re, rs2_re, imm, rd, rs1, rs2} = dec_q;
endmodule

// File: tb/tb_axo32_decoder.sv
// tb_axo32_decoder: table-driven scoreboard bench for the registered RV32I decoder
module tb_axo32_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst = '0;
    logic        op_valid, op_will_read, op_will_write, op_uses_alu, op_does_flowctl;
    logic        op_is_ecall, op_is_ebreak, op_32bit, op_is_imm, rd_we, rs1_re, rs2_re;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;

    axo32_decoder dut (
        .clk(clk), .rst_n(rst_n), .inst(inst),
        .op_valid(op_valid), .op_will_read(op_will_read), .op_will_write(op_will_write),
        .op_uses_alu(op_uses_alu), .op_does_flowctl(op_does_flowctl),
        .op_is_ecall(op_is_ecall), .op_is_ebreak(op_is_ebreak), .op_32bit(op_32bit),
        .op_is_imm(op_is_imm), .imm(imm), .rd_we(rd_we), .rs1_re(rs1_re), .rs2_re(rs2_re),
        .rd(rd), .rs1(rs1), .rs2(rs2)
    );

    always #5 clk = ~clk;

    // flag order: valid 32bit read write alu flowctl ecall ebreak is_imm rd_we rs1_re rs2_re
    typedef struct packed {
        logic [31:0] inst;
        logic [11:0] f;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [11:0] act_flags();
        return {op_valid, op_32bit, op_will_read, op_will_write, op_uses_alu, op_does_flowctl,
                op_is_ecall, op_is_ebreak, op_is_imm, rd_we, rs1_re, rs2_re};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        vec_t e;
        @(negedge clk);
        inst = v.inst;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check($sformatf("flags_%h", e.inst), {52'b0, act_flags()}, {52'b0, e.f});
            check($sformatf("imm_%h", e.inst), {32'b0, imm}, {32'b0, e.imm});
            check($sformatf("fields_%h", e.inst), {49'b0, rd, rs1, rs2},
                  {49'b0, e.inst[11:7], e.inst[19:15], e.inst[24:20]});
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {20'b0, act_flags(), imm}, 64'b0);
        check({name, "_fields"}, {49'b0, rd, rs1, rs2}, 64'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{32'h0050_0093, 12'b1100_1000_1110, 32'h0000_0005}); // addi x1,x0,5
        vecs.push_back('{32'h1234_5137, 12'b1100_0000_1100, 32'h1234_5000}); // lui x2
        vecs.push_back('{32'hFE20_8EE3, 12'b1100_0100_0011, 32'hFFFF_FFFC}); // beq -4
        vecs.push_back('{32'h0020_A423, 12'b1101_0000_0011, 32'h0000_0008}); // sw x2,8(x1)
        vecs.push_back('{32'hFFF0_A183, 12'b1110_0000_1110, 32'hFFFF_FFFF}); // lw x3,-1(x1)
        vecs.push_back('{32'h0000_0013, 12'b1100_1000_1010, 32'h0000_0000}); // nop, rd_we suppressed
        vecs.push_back('{32'h0000_0073, 12'b1100_0010_0000, 32'h0000_0000}); // ecall
        vecs.push_back('{32'h0010_0073, 12'b1100_0001_0000, 32'h0000_0000}); // ebreak
        vecs.push_back('{32'h0000_0000, 12'b0000_0000_0000, 32'h0000_0000}); // all zero
        vecs.push_back('{32'h0000_1073, 12'b0100_0000_0000, 32'h0000_0000}); // csrrw
        vecs.push_back('{32'h4000_1033, 12'b0100_0000_0000, 32'h0000_0000}); // sub funct3 001
        vecs.push_back('{32'h0080_00EF, 12'b1100_0100_1100, 32'h0000_0008}); // jal x1,8
        vecs.push_back('{32'h0000_80E7, 12'b1100_0100_1110, 32'h0000_0000}); // jalr x1,0(x1)
        vecs.push_back('{32'h0000_90E7, 12'b0100_0000_0000, 32'h0000_0000}); // jalr funct3 001
        vecs.push_back('{32'hFFFF_F097, 12'b1100_1000_1100, 32'hFFFF_F000}); // auipc
        vecs.push_back('{32'h4030_D093, 12'b1100_1000_1110, 32'h0000_0403}); // srai x1,x1,3
        vecs.push_back('{32'h4030_9093, 12'b0100_0000_0000, 32'h0000_0000}); // slli bad funct7
        vecs.push_back('{32'h4020_80B3, 12'b1100_1000_0111, 32'h0000_0000}); // sub x1,x1,x2
        vecs.push_back('{32'h0000_2063, 12'b0100_0000_0000, 32'h0000_0000}); // branch funct3 010
        vecs.push_back('{32'h0000_B083, 12'b0100_0000_0000, 32'h0000_0000}); // load funct3 011
        vecs.push_back('{32'h0000_B023, 12'b0100_0000_0000, 32'h0000_0000}); // store funct3 011
        vecs.push_back('{32'h0FF0_000F, 12'b1100_0000_0000, 32'h0000_0000}); // fence
        vecs.push_back('{32'h1234_5135, 12'b0000_0000_0000, 32'h0000_0000}); // low bits 01

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

        // async reset with nonzero outputs held: must clear without a clock edge
        drive('{32'hFFF0_A183, 12'b1110_0000_1110, 32'hFFFF_FFFF});
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive('{32'h0050_0093, 12'b1100_1000_1110, 32'h0000_0005});
        drive('{32'h0000_0000, 12'b0000_0000_0000, 32'h0000_0000});
        check("sb_drained", {32'b0, 32'(sb.size())}, 64'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axo32_decoder.md
Name: axo32_decoder

Overview:
- Registered RV32I base-ISA instruction decoder for the Axolotl³² core.
- Takes the 32-bit instruction word and produces, one clock later:
  - operation-class flags,
  - register indices with read/write enables,
  - the sign-extended immediate,
  - a validity flag.
- The core uses op_valid to raise the illegal-instruction crash.

Parameters:
- None. XLEN is fixed at 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inst  input  32  instruction word to decode
- op_valid  output  1  instruction is legal RV32I
- op_will_read  output  1  LOAD: memory read
- op_will_write  output  1  STORE: memory write
- op_uses_alu  output  1  rd result comes from the ALU (OP, OP-IMM, AUIPC)
- op_does_flowctl  output  1  JAL, JALR, BRANCH
- op_is_ecall  output  1  ECALL
- op_is_ebreak  output  1  EBREAK
- op_32bit  output  1  inst[1:0]==2'b11 (non-compressed encoding)
- op_is_imm  output  1  operand 2 is imm, not rs2
- imm  output  32  sign-extended immediate
- rd_we  output  1  write rd
- rs1_re  output  1  read rs1
- rs2_re  output  1  read rs2
- rd  output  5  inst[11:7]
- rs1  output  5  inst[19:15]
- rs2  output  5  inst[24:20]

Behaviour:
- Reset
  - While rst_n is low, all outputs are 0 immediately, independent of clk.
- Latency
  - All outputs are registered.
  - On each rising clk with rst_n high, outputs reflect the decode of the inst value sampled at that edge (1-cycle latency, no stall or handshake).
- Field outputs
  - rd, rs1 and rs2 are always the raw fields, even for invalid instructions.
- op_32bit
  - Equals inst[1:0]==2'b11.
  - op_valid requires op_32bit.
- Immediate formats (sign bit inst[31])
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type and invalid: imm=0.
- Decode by opcode inst[6:0]; flags not listed are 0:
  - 0110111 LUI: U; rd_we, op_is_imm.
  - 0010111 AUIPC: U; rd_we, op_is_imm, op_uses_alu. PC is supplied as operand 1 by the core.
  - 1101111 JAL: J; rd_we, op_is_imm, op_does_flowctl.
  - 1100111 JALR: funct3 must be 000; I; rd_we, rs1_re, op_is_imm, op_does_flowctl.
  - 1100011 BRANCH: funct3 must not be 010 or 011; B; rs1_re, rs2_re, op_does_flowctl.
  - 0000011 LOAD: funct3 in {000, 001, 010, 100, 101}; I; rd_we, rs1_re, op_is_imm, op_will_read.
  - 0100011 STORE: funct3 in {000, 001, 010}; S; rs1_re, rs2_re, op_will_write.
  - 0010011 OP-IMM: I; rd_we, rs1_re, op_is_imm, op_uses_alu.
    - funct3 001 requires inst[31:25]=0000000.
    - funct3 101 requires inst[31:25] in {0000000, 0100000}.
    - For shifts, imm is still the full I-immediate; the ALU uses the low 5 bits and inst[30].
  - 0110011 OP: rd_we, rs1_re, rs2_re, op_uses_alu.
    - inst[31:25]=0000000 is valid for any funct3.
    - inst[31:25]=0100000 is valid only for funct3 000 or 101.
  - 0001111 MISC-MEM (FENCE): op_valid only; treated as a NOP.
  - 1110011 SYSTEM:
    - inst==0x00000073 gives op_is_ecall.
    - inst==0x00100073 gives op_is_ebreak.
    - Anything else (including CSR instructions) is invalid.
- rd_we is forced to 0 when rd==0 (x0 write suppressed).
- Invalid instruction (any opcode, funct or op_32bit mismatch):
  - op_valid=0, imm=0, all flags and enables 0.
  - op_32bit still reflects inst[1:0].
- op_is_imm and rs2_re are never both 1.

Test Plan:
- Reset: drive rst_n=0 asynchronously while outputs are nonzero → all outputs 0 without a clk edge. Release, apply 0x00500093 → after one edge, decode appears.
- addi x1,x0,5 (0x00500093) → op_valid=1, rd=1, rs1=0, imm=0x00000005, op_uses_alu, op_is_imm, rd_we, rs1_re; rs2_re=0.
- lui x2,0x12345 (0x12345137) → imm=0x12345000, rd=2, rd_we, op_is_imm; op_uses_alu=0, rs1_re=0.
- beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, rs1=1, rs2=2, rs1_re, rs2_re, op_does_flowctl; rd_we=0. sw x2,8(x1) (0x0020A423) → imm=8, op_will_write, rs1_re, rs2_re.
- lw x3,-1(x1) (0xFFF0A183) → imm=0xFFFFFFFF, op_will_read, rd=3. addi x0,x0,0 (0x00000013) → op_valid=1, rd_we=0.
- ecall (0x00000073) → op_is_ecall=1. ebreak (0x00100073) → op_is_ebreak=1. 0x00000000, csrrw (0x00001073), sub with funct3 001 (0x40001033) → op_valid=0, imm=0, all flags 0.
